// File: rtl/flit_stats_accumulator.sv
// Per-packet length and per-window byte/packet/flit statistics for snooped AXI-Stream beats.
// Handshake: a beat counts only when snoop_tvalid && snoop_tready; bytes_in_flit arrives one cycle later.
module flit_stats_accumulator #(
  parameter int WINDOW_WIDTH   = 32,
  parameter int BYTE_CNT_WIDTH = 48,
  parameter int PKT_CNT_WIDTH  = 32,
  parameter int PKT_LEN_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      snoop_tvalid,
  input  logic                      snoop_tready,
  input  logic                      snoop_tlast,
  input  logic [7:0]                bytes_in_flit,
  input  logic                      enable,
  input  logic [WINDOW_WIDTH-1:0]   window_cycles,
  output logic                      pkt_len_valid,
  output logic [PKT_LEN_WIDTH-1:0]  pkt_len,
  output logic                      stats_valid,
  output logic [BYTE_CNT_WIDTH-1:0] stats_bytes,
  output logic [PKT_CNT_WIDTH-1:0]  stats_packets,
  output logic [PKT_CNT_WIDTH-1:0]  stats_flits,
  output logic [PKT_LEN_WIDTH-1:0]  stats_max_pkt_len,
  output logic                      stats_overflow
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_q;
  logic                      beat_q, last_q;
  logic [WINDOW_WIDTH-1:0]   win_cnt_q, win_len;
  logic [PKT_LEN_WIDTH-1:0]  pkt_acc_q, pkt_len_q, pkt_sum;
  logic [PKT_LEN_WIDTH:0]    pkt_sum_wide;
  logic                      pkt_len_valid_q;
  logic [BYTE_CNT_WIDTH-1:0] acc_bytes_q, acc_bytes_d, stats_bytes_q;
  logic [BYTE_CNT_WIDTH:0]   bytes_wide;
  logic [PKT_CNT_WIDTH-1:0]  acc_pkts_q, acc_pkts_d, stats_pkts_q;
  logic [PKT_CNT_WIDTH-1:0]  acc_flits_q, acc_flits_d, stats_flits_q;
  logic [PKT_CNT_WIDTH:0]    pkts_wide, flits_wide;
  logic [PKT_LEN_WIDTH-1:0]  acc_max_q, acc_max_d, stats_max_q;
  logic                      acc_ovf_q, acc_ovf_d, stats_ovf_q, stats_valid_q;
  logic                      win_end, win_keep;

  // A programmed window length of 0 behaves as a 1-cycle window.
  assign win_len = (window_cycles == '0) ? WINDOW_WIDTH'(1) : window_cycles;

  assign pkt_sum_wide = {1'b0, pkt_acc_q} + (PKT_LEN_WIDTH+1)'(bytes_in_flit);
  assign pkt_sum      = pkt_sum_wide[PKT_LEN_WIDTH] ? '1 : pkt_sum_wide[PKT_LEN_WIDTH-1:0];
  assign bytes_wide   = {1'b0, acc_bytes_q} + (BYTE_CNT_WIDTH+1)'(bytes_in_flit);
  assign flits_wide   = {1'b0, acc_flits_q} + (PKT_CNT_WIDTH+1)'(1);
  assign pkts_wide    = {1'b0, acc_pkts_q} + (PKT_CNT_WIDTH+1)'(1);

  assign win_end  = (state_q == RUN) && enable && (win_cnt_q == WINDOW_WIDTH'(1));
  assign win_keep = (state_q == RUN) && enable && !win_end;

  // Window accumulators including the current aligned beat; the top bit of each wide sum flags saturation.
  always_comb begin
    acc_bytes_d = acc_bytes_q;
    acc_flits_d = acc_flits_q;
    acc_pkts_d  = acc_pkts_q;
    acc_max_d   = acc_max_q;
    acc_ovf_d   = acc_ovf_q;
    if (beat_q) begin
      acc_bytes_d = bytes_wide[BYTE_CNT_WIDTH] ? '1 : bytes_wide[BYTE_CNT_WIDTH-1:0];
      acc_flits_d = flits_wide[PKT_CNT_WIDTH] ? '1 : flits_wide[PKT_CNT_WIDTH-1:0];
      acc_ovf_d   = acc_ovf_q | bytes_wide[BYTE_CNT_WIDTH] | flits_wide[PKT_CNT_WIDTH];
      if (last_q) begin
        acc_pkts_d = pkts_wide[PKT_CNT_WIDTH] ? '1 : pkts_wide[PKT_CNT_WIDTH-1:0];
        acc_ovf_d  = acc_ovf_d | pkts_wide[PKT_CNT_WIDTH];
        if (pkt_sum > acc_max_q) acc_max_d = pkt_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      beat_q          <= 1'b0;
      last_q          <= 1'b0;
      win_cnt_q       <= '0;
      pkt_acc_q       <= '0;
      pkt_len_q       <= '0;
      pkt_len_valid_q <= 1'b0;
      acc_bytes_q     <= '0;
      acc_flits_q     <= '0;
      acc_pkts_q      <= '0;
      acc_max_q       <= '0;
      acc_ovf_q       <= 1'b0;
      stats_valid_q   <= 1'b0;
      stats_bytes_q   <= '0;
      stats_pkts_q    <= '0;
      stats_flits_q   <= '0;
      stats_max_q     <= '0;
      stats_ovf_q     <= 1'b0;
    end else begin
      beat_q          <= snoop_tvalid & snoop_tready;
      last_q          <= snoop_tvalid & snoop_tready & snoop_tlast;
      pkt_len_valid_q <= 1'b0;
      stats_valid_q   <= 1'b0;

      // Packet tracking runs regardless of window state.
      if (beat_q) begin
        if (last_q) begin
          pkt_len_q       <= pkt_sum;
          pkt_len_valid_q <= 1'b1;
          pkt_acc_q       <= '0;
        end else begin
          pkt_acc_q <= pkt_sum;
        end
      end

      if (win_keep) begin
        acc_bytes_q <= acc_bytes_d;
        acc_flits_q <= acc_flits_d;
        acc_pkts_q  <= acc_pkts_d;
        acc_max_q   <= acc_max_d;
        acc_ovf_q   <= acc_ovf_d;
      end else begin
        acc_bytes_q <= '0;
        acc_flits_q <= '0;
        acc_pkts_q  <= '0;
        acc_max_q   <= '0;
        acc_ovf_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= RUN;
            win_cnt_q <= win_len;
          end
        end
        RUN: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (win_end) begin
            stats_valid_q <= 1'b1;
            stats_bytes_q <= acc_bytes_d;
            stats_flits_q <= acc_flits_d;
            stats_pkts_q  <= acc_pkts_d;
            stats_max_q   <= acc_max_d;
            stats_ovf_q   <= acc_ovf_d;
            win_cnt_q     <= win_len;
          end else begin
            win_cnt_q <= win_cnt_q - WINDOW_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign pkt_len_valid     = pkt_len_valid_q;
  assign pkt_len           = pkt_len_q;
  assign stats_valid       = stats_valid_q;
  assign stats_bytes       = stats_bytes_q;
  assign stats_packets     = stats_pkts_q;
  assign stats_flits       = stats_flits_q;
  assign stats_max_pkt_len = stats_max_q;
  assign stats_overflow    = stats_ovf_q;
endmodule

// File: tb/tb_flit_stats_accumulator.sv
// Bench for flit_stats_accumulator: table of packets plus window sequences, checked through expected queues.
module tb_flit_stats_accumulator;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        snoop_tvalid = 1'b0, snoop_tready = 1'b0, snoop_tlast = 1'b0;
  logic [7:0]  bytes_in_flit = 8'd0, pend_bytes = 8'd0;
  logic        enable = 1'b0, en_sat = 1'b0;
  logic [31:0] window_cycles = 32'd1;

  logic        pkt_len_valid, stats_valid, stats_overflow;
  logic [15:0] pkt_len, stats_max_pkt_len;
  logic [47:0] stats_bytes;
  logic [31:0] stats_packets, stats_flits;

  logic        sat_pkt_len_valid, sat_stats_valid, sat_overflow;
  logic [15:0] sat_pkt_len, sat_max;
  logic [7:0]  sat_bytes;
  logic [31:0] sat_packets, sat_flits;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [47:0] bytes;
    logic [31:0] pkts;
    logic [31:0] flits;
    logic [15:0] maxl;
    logic        ovf;
  } stats_t;
  localparam int SW = $bits(stats_t);

  logic [47:0]   exp_pkt_q[$];
  logic [SW-1:0] exp_stats_q[$];
  logic [SW-1:0] exp_sat_q[$];

  typedef struct {
    int          n;
    logic [63:0] b;
    int          gap;
    logic [15:0] exp;
  } pkt_vec_t;
  pkt_vec_t vecs[6];

  flit_stats_accumulator dut (
    .clk(clk), .aresetn(aresetn),
    .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tlast(snoop_tlast),
    .bytes_in_flit(bytes_in_flit), .enable(enable), .window_cycles(window_cycles),
    .pkt_len_valid(pkt_len_valid), .pkt_len(pkt_len),
    .stats_valid(stats_valid), .stats_bytes(stats_bytes), .stats_packets(stats_packets),
    .stats_flits(stats_flits), .stats_max_pkt_len(stats_max_pkt_len), .stats_overflow(stats_overflow)
  );

  flit_stats_accumulator #(.BYTE_CNT_WIDTH(8)) dut_sat (
    .clk(clk), .aresetn(aresetn),
    .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tlast(snoop_tlast),
    .bytes_in_flit(bytes_in_flit), .enable(en_sat), .window_cycles(window_cycles),
    .pkt_len_valid(sat_pkt_len_valid), .pkt_len(sat_pkt_len),
    .stats_valid(sat_stats_valid), .stats_bytes(sat_bytes), .stats_packets(sat_packets),
    .stats_flits(sat_flits), .stats_max_pkt_len(sat_max), .stats_overflow(sat_overflow)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] mk_stats(input int c, input logic [47:0] by, input int p,
                                             input int f, input int m, input logic o);
    stats_t s;
    s.cyc = 32'(c); s.bytes = by; s.pkts = 32'(p); s.flits = 32'(f); s.maxl = 16'(m); s.ovf = o;
    return s;
  endfunction

  // Driver tasks: beat signals go out this cycle, their byte count one cycle later.
  task automatic step(input logic v, input logic r, input logic l, input logic [7:0] b);
    snoop_tvalid  = v;
    snoop_tready  = r;
    snoop_tlast   = l;
    bytes_in_flit = pend_bytes;
    pend_bytes    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_packet(input int n, input logic [63:0] b, input int gap, input logic [15:0] exp_len);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) exp_pkt_q.push_back({32'(cyc + 2), exp_len});
      step(1'b1, 1'b1, i == n - 1, b[i*8 +: 8]);
      for (int g = 0; g < gap && i < n - 1; g++) step(1'b1, 1'b0, 1'b1, 8'hAA);
    end
  endtask

  task automatic send_uniform(input int n, input logic [7:0] bval, input logic [15:0] exp_len);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) exp_pkt_q.push_back({32'(cyc + 2), exp_len});
      step(1'b1, 1'b1, i == n - 1, bval);
    end
  endtask

  // Scoreboard: pop on every output pulse and compare content and arrival cycle.
  logic [47:0] mon_pkt;
  stats_t      mon_st, mon_sat;

  always @(negedge clk) if (aresetn && pkt_len_valid) begin
    if (exp_pkt_q.size() == 0) check("pkt_unexpected", 64'd1, 64'd0);
    else begin
      mon_pkt = exp_pkt_q.pop_front();
      check("pkt_len", 64'(pkt_len), 64'(mon_pkt[15:0]));
      check("pkt_cycle", 64'(cyc), 64'(mon_pkt[47:16]));
    end
  end

  always @(negedge clk) if (aresetn && stats_valid) begin
    if (exp_stats_q.size() == 0) check("stats_unexpected", 64'd1, 64'd0);
    else begin
      mon_st = exp_stats_q.pop_front();
      check("stats_cycle", 64'(cyc), 64'(mon_st.cyc));
      check("stats_bytes", 64'(stats_bytes), 64'(mon_st.bytes));
      check("stats_packets", 64'(stats_packets), 64'(mon_st.pkts));
      check("stats_flits", 64'(stats_flits), 64'(mon_st.flits));
      check("stats_max", 64'(stats_max_pkt_len), 64'(mon_st.maxl));
      check("stats_ovf", 64'(stats_overflow), 64'(mon_st.ovf));
    end
  end

  always @(negedge clk) if (aresetn && sat_stats_valid) begin
    if (exp_sat_q.size() == 0) check("sat_unexpected", 64'd1, 64'd0);
    else begin
      mon_sat = exp_sat_q.pop_front();
      check("sat_cycle", 64'(cyc), 64'(mon_sat.cyc));
      check("sat_bytes", 64'(sat_bytes), 64'(mon_sat.bytes));
      check("sat_packets", 64'(sat_packets), 64'(mon_sat.pkts));
      check("sat_flits", 64'(sat_flits), 64'(mon_sat.flits));
      check("sat_max", 64'(sat_max), 64'(mon_sat.maxl));
      check("sat_ovf", 64'(sat_overflow), 64'(mon_sat.ovf));
    end
  end

  initial begin
    int c0;
    vecs[0] = '{3, 64'h0000_0000_0008_1010, 0, 16'd40};
    vecs[1] = '{1, 64'h0000_0000_0000_0000, 0, 16'd0};
    vecs[2] = '{4, 64'h0000_0000_FFFF_FFFF, 1, 16'd1020};
    vecs[3] = '{2, 64'h0000_0000_0000_FE01, 0, 16'd255};
    vecs[4] = '{5, 64'h0000_0000_0007_0000, 2, 16'd7};
    vecs[5] = '{8, 64'h0102_0304_0506_0708, 0, 16'd36};

    // Reset held while beats toggle: every output stays 0.
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b1, i == 1, 8'(i + 3));
      check("rst_pkt", {47'd0, pkt_len_valid, pkt_len}, 64'd0);
      check("rst_stats_v", 64'(stats_valid), 64'd0);
      check("rst_stats_bytes", 64'(stats_bytes), 64'd0);
      check("rst_stats_cnt", {stats_packets, stats_flits}, 64'd0);
      check("rst_stats_max_ovf", {47'd0, stats_overflow, stats_max_pkt_len}, 64'd0);
    end
    aresetn = 1'b1;
    idle();
    idle();

    // Table of packets, windows disabled.
    for (int v = 0; v < 6; v++) begin
      send_packet(vecs[v].n, vecs[v].b, vecs[v].gap, vecs[v].exp);
      idle();
    end
    repeat (3) idle();

    // W=10: 40-byte and 16-byte packets inside one window.
    window_cycles = 32'd10;
    enable = 1'b1;
    c0 = cyc;
    exp_stats_q.push_back(mk_stats(c0 + 11, 48'd56, 2, 4, 40, 1'b0));
    idle();
    send_packet(3, 64'h081010, 0, 16'd40);
    idle();
    send_packet(1, 64'h10, 0, 16'd16);
    for (int k = 0; k < 40 && cyc < c0 + 12; k++) idle();
    enable = 1'b0;
    idle();
    repeat (2) idle();

    // W=4: a six-beat packet straddling two windows.
    window_cycles = 32'd4;
    enable = 1'b1;
    c0 = cyc;
    exp_stats_q.push_back(mk_stats(c0 + 5, 48'd64, 0, 4, 0, 1'b0));
    exp_stats_q.push_back(mk_stats(c0 + 9, 48'd32, 1, 2, 96, 1'b0));
    send_uniform(6, 8'd16, 16'd96);
    for (int k = 0; k < 40 && cyc < c0 + 10; k++) idle();
    enable = 1'b0;
    idle();
    repeat (2) idle();

    // Mid-window disable discards the window; stats keep the last completed window.
    window_cycles = 32'd8;
    enable = 1'b1;
    idle();
    send_packet(2, 64'h1010, 0, 16'd32);
    enable = 1'b0;
    idle();
    repeat (12) idle();
    check("hold_bytes", 64'(stats_bytes), 64'd32);
    check("hold_packets", 64'(stats_packets), 64'd1);
    check("hold_flits", 64'(stats_flits), 64'd2);
    check("hold_max", 64'(stats_max_pkt_len), 64'd96);

    // Re-enable: stalled beats ignored, last beat on the window's final cycle belongs to it.
    enable = 1'b1;
    c0 = cyc;
    exp_stats_q.push_back(mk_stats(c0 + 9, 48'd8, 1, 1, 8, 1'b0));
    repeat (5) step(1'b1, 1'b0, 1'b1, 8'h77);
    idle();
    idle();
    send_packet(1, 64'h08, 0, 16'd8);
    send_packet(1, 64'h04, 0, 16'd4);
    for (int k = 0; k < 40 && cyc < c0 + 10; k++) idle();
    enable = 1'b0;
    idle();
    repeat (2) idle();

    // Byte accumulator saturation in the 8-bit instance, then an idle window clears it.
    window_cycles = 32'd25;
    enable = 1'b1;
    en_sat = 1'b1;
    c0 = cyc;
    exp_stats_q.push_back(mk_stats(c0 + 26, 48'd320, 1, 20, 320, 1'b0));
    exp_stats_q.push_back(mk_stats(c0 + 51, 48'd0, 0, 0, 0, 1'b0));
    exp_sat_q.push_back(mk_stats(c0 + 26, 48'd255, 1, 20, 320, 1'b1));
    exp_sat_q.push_back(mk_stats(c0 + 51, 48'd0, 0, 0, 0, 1'b0));
    send_uniform(20, 8'd16, 16'd320);
    for (int k = 0; k < 80 && cyc < c0 + 52; k++) idle();
    enable = 1'b0;
    en_sat = 1'b0;
    idle();
    repeat (2) idle();

    // Packet length saturates at all-ones, next packet starts from 0.
    send_uniform(260, 8'd255, 16'hFFFF);
    idle();
    send_packet(1, 64'h05, 0, 16'd5);

    for (int k = 0; k < 200 && (exp_pkt_q.size() != 0 || exp_stats_q.size() != 0 || exp_sat_q.size() != 0); k++)
      idle();
    repeat (4) idle();
    check("pkt_q_drained", 64'(exp_pkt_q.size()), 64'd0);
    check("stats_q_drained", 64'(exp_stats_q.size()), 64'd0);
    check("sat_q_drained", 64'(exp_sat_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
